// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Double-buffered hex digits, per-slot blanking, registered outputs.
module display_scanner #(
   parameter int unsigned TICKS_PER_DIGIT = 100000,
   parameter int unsigned BLANK_TICKS     = 1000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] Value,
   input  logic [3:0]  DigitEnable,
   input  logic        Load,
   output logic [1:0]  Count,
   output logic [6:0]  Segments,
   output logic        FrameDone
);

   localparam int unsigned TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t        state, state_n;
   logic [TW-1:0] tick, tick_n;
   logic [1:0]    count_n;
   logic [15:0]   stg_val, act_val, act_val_n;
   logic [3:0]    stg_en, act_en, act_en_n;
   logic          pending, pending_n;
   logic          slot_end, frame_end;
   logic [3:0]    nibble;
   logic [6:0]    segments_n;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      case (n)
         4'h0: hex_decode = 7'b1000000;
         4'h1: hex_decode = 7'b1111001;
         4'h2: hex_decode = 7'b0100100;
         4'h3: hex_decode = 7'b0110000;
         4'h4: hex_decode = 7'b0011001;
         4'h5: hex_decode = 7'b0010010;
         4'h6: hex_decode = 7'b0000010;
         4'h7: hex_decode = 7'b1111000;
         4'h8: hex_decode = 7'b0000000;
         4'h9: hex_decode = 7'b0010000;
         4'hA: hex_decode = 7'b0001000;
         4'hB: hex_decode = 7'b0000011;
         4'hC: hex_decode = 7'b1000110;
         4'hD: hex_decode = 7'b0100001;
         4'hE: hex_decode = 7'b0000110;
         default: hex_decode = 7'b0001110;
      endcase
   endfunction

   // Segments are computed from next-cycle state so Count, FSM and pattern
   // all change on the same edge.
   always_comb begin
      slot_end  = (tick == TICK_LAST);
      frame_end = slot_end && (Count == 2'd3);
      tick_n    = slot_end ? '0 : tick + TW'(1);
      count_n   = slot_end ? Count + 2'd1 : Count;

      state_n = state;
      if (slot_end)
         state_n = BLANK;
      else if (tick == BLANK_LAST)
         state_n = SHOW;

      act_val_n = act_val;
      act_en_n  = act_en;
      pending_n = pending;
      if (Load)
         pending_n = 1'b1;
      if (frame_end) begin
         pending_n = 1'b0;
         if (Load) begin
            act_val_n = Value;
            act_en_n  = DigitEnable;
         end else if (pending) begin
            act_val_n = stg_val;
            act_en_n  = stg_en;
         end
      end

      nibble = act_val_n[{count_n, 2'b00} +: 4];
      if (state_n == SHOW && act_en_n[count_n])
         segments_n = hex_decode(nibble);
      else
         segments_n = '1;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         tick      <= '0;
         Count     <= '0;
         state     <= BLANK;
         stg_val   <= '0;
         stg_en    <= '0;
         act_val   <= '0;
         act_en    <= '0;
         pending   <= 1'b0;
         Segments  <= '1;
         FrameDone <= 1'b0;
      end else begin
         tick      <= tick_n;
         Count     <= count_n;
         state     <= state_n;
         act_val   <= act_val_n;
         act_en    <= act_en_n;
         pending   <= pending_n;
         Segments  <= segments_n;
         FrameDone <= frame_end;
         if (Load) begin
            stg_val <= Value;
            stg_en  <= DigitEnable;
         end
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares; directed spot checks use literal patterns.
module tb_display_scanner;

   logic        Clock;
   logic        Reset;
   logic [15:0] Value;
   logic [3:0]  DigitEnable;
   logic        Load;
   logic [1:0]  Count;
   logic [6:0]  Segments;
   logic        FrameDone;

   display_scanner #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2)) dut (
      .Clock(Clock), .Reset(Reset), .Value(Value), .DigitEnable(DigitEnable),
      .Load(Load), .Count(Count), .Segments(Segments), .FrameDone(FrameDone)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   typedef struct {
      logic [1:0] cnt;
      logic [6:0] seg;
      logic       fd;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model: c counts cycles since reset release
   int          c = 0;
   logic [15:0] m_act_val = '0, m_stg_val = '0;
   logic [3:0]  m_act_en = '0, m_stg_en = '0;
   logic        m_pend = 1'b0;

   function automatic logic [6:0] hexseg(input logic [3:0] n);
      logic [6:0] t[16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[n];
   endfunction

   function automatic exp_t predict(input int cc);
      exp_t e;
      int   tk, dg;
      tk = cc % 8;
      dg = (cc / 8) % 4;
      e.cnt = 2'(dg);
      e.fd  = (cc != 0) && (cc % 32 == 0);
      e.cyc = cc;
      if (tk >= 2 && m_act_en[dg])
         e.seg = hexseg(m_act_val[dg*4 +: 4]);
      else
         e.seg = 7'h7F;
      return e;
   endfunction

   task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic [3:0] en);
      bit fb;
      Reset = rst; Load = ld; Value = v; DigitEnable = en;
      @(posedge Clock);
      if (rst) begin
         c = 0;
         m_act_val = '0; m_act_en = '0; m_stg_val = '0; m_stg_en = '0; m_pend = 1'b0;
      end else begin
         fb = (c % 8 == 7) && ((c / 8) % 4 == 3);
         if (fb) begin
            if (ld) begin
               m_act_val = v; m_act_en = en;
            end else if (m_pend) begin
               m_act_val = m_stg_val; m_act_en = m_stg_en;
            end
            m_pend = 1'b0;
         end
         if (ld) begin
            m_stg_val = v; m_stg_en = en;
            if (!fb) m_pend = 1'b1;
         end
         c++;
      end
      q.push_back(predict(c));
      #1;
      Load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
   endtask

   // advance until the model sits on digit dg, tick tk (bounded)
   task automatic run_to(input int dg, input int tk);
      int k;
      for (k = 0; k < 40; k++) begin
         if ((c % 8 == tk) && ((c / 8) % 4 == dg)) break;
         idle(1);
      end
      if (k == 40) begin
         errors++;
         checks++;
         $display("FAIL run_to digit=%0d tick=%0d not reached within 40 cycles", dg, tk);
      end
   endtask

   task automatic spot(input string name, input logic [6:0] act, input logic [6:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%b expected=%b", name, act, req);
      end
   endtask

   always @(negedge Clock) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (Count !== e.cnt || Segments !== e.seg || FrameDone !== e.fd) begin
            errors++;
            $display("FAIL cycle c=%0d got cnt=%0d seg=%b fd=%b expected cnt=%0d seg=%b fd=%b",
                     e.cyc, Count, Segments, FrameDone, e.cnt, e.seg, e.fd);
         end
      end
   end

   initial begin
      Reset = 1'b1; Load = 1'b0; Value = '0; DigitEnable = '0;

      // 1. reset and free-run
      step(1'b1, 1'b0, 16'h0, 4'h0);
      step(1'b1, 1'b0, 16'h0, 4'h0);
      step(1'b1, 1'b0, 16'h0, 4'h0);
      spot("reset_count", {5'b0, Count}, 7'd0);
      spot("reset_segments", Segments, 7'h7F);
      spot("reset_framedone", {6'b0, FrameDone}, 7'd0);
      idle(32);
      spot("frame_done_pulse", {6'b0, FrameDone}, 7'd1);
      spot("frame_wrap_count", {5'b0, Count}, 7'd0);
      idle(1);
      spot("frame_done_one_cycle", {6'b0, FrameDone}, 7'd0);

      // 2. load at digit 1; shadow must not change before the boundary
      run_to(1, 0);
      step(1'b0, 1'b1, 16'h3A0F, 4'hF);
      run_to(2, 4);
      spot("no_tearing", Segments, 7'h7F);
      run_to(0, 1);
      spot("blank_interval", Segments, 7'h7F);
      idle(1);
      spot("digit0_F", Segments, 7'b0001110);
      run_to(1, 2);
      spot("digit1_0", Segments, 7'b1000000);
      run_to(2, 7);
      spot("digit2_A", Segments, 7'b0001000);
      run_to(3, 2);
      spot("digit3_3", Segments, 7'b0110000);

      // 3. per-digit enable
      step(1'b0, 1'b1, 16'h8888, 4'b0101);
      run_to(0, 3);
      spot("en_digit0_on", Segments, 7'b0000000);
      run_to(1, 3);
      spot("en_digit1_off", Segments, 7'h7F);
      run_to(2, 3);
      spot("en_digit2_on", Segments, 7'b0000000);
      run_to(3, 3);
      spot("en_digit3_off", Segments, 7'h7F);

      // 4. load exactly on the frame boundary, then double load
      run_to(3, 7);
      step(1'b0, 1'b1, 16'h1111, 4'hF);
      spot("boundary_blank", Segments, 7'h7F);
      idle(2);
      spot("boundary_load_digit0", Segments, 7'b1111001);
      run_to(0, 3);
      step(1'b0, 1'b1, 16'h2222, 4'hF);
      run_to(2, 0);
      step(1'b0, 1'b1, 16'h5555, 4'hF);
      run_to(3, 5);
      spot("old_value_held", Segments, 7'b1111001);
      run_to(0, 4);
      spot("last_load_wins_d0", Segments, 7'b0010010);
      run_to(1, 4);
      spot("last_load_wins_d1", Segments, 7'b0010010);

      // 5. mid-operation reset
      run_to(2, 5);
      step(1'b1, 1'b0, 16'h0, 4'h0);
      spot("midreset_count", {5'b0, Count}, 7'd0);
      spot("midreset_segments", Segments, 7'h7F);
      spot("midreset_framedone", {6'b0, FrameDone}, 7'd0);
      idle(4);
      spot("dark_after_reset", Segments, 7'h7F);
      idle(36);
      step(1'b0, 1'b1, 16'h0001, 4'b0001);
      run_to(1, 0);
      run_to(0, 2);
      spot("relit_after_load", Segments, 7'b1111001);
      idle(3);

      @(negedge Clock);
      @(negedge Clock);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain leftover=%0d expected=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing scan controller for the 4-digit seven-segment display. It latches four hex nibbles in a double buffer and steps a 2-bit digit index, which feeds the anode decoder's `Count` input. It drives the shared active-low segment bus with the decoded pattern for the selected digit, and inserts a blanking interval at the start of every digit slot to suppress ghosting. It sits between the note/status logic and the anode decoder plus output pins.

## Interface
Parameters:
- `TICKS_PER_DIGIT`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range 2..2^20.
- `BLANK_TICKS`, default 1000: cycles at the start of each slot with segments forced off. Legal range 1 ≤ `BLANK_TICKS` < `TICKS_PER_DIGIT`.

Ports:
- `Clock`, in, 1: sole clock, rising edge.
- `Reset`, in, 1: reset is synchronous and active-high.
- `Value`, in, 16: four hex digits; digit n = `Value[4n+3:4n]`.
- `DigitEnable`, in, 4: bit n high means digit n is shown; low means that digit stays blank.
- `Load`, in, 1: single-cycle strobe that captures `Value` and `DigitEnable` into staging.
- `Count`, out, 2: current digit index, wired to the anode decoder.
- `Segments`, out, 7: active-low {g,f,e,d,c,b,a}.
- `FrameDone`, out, 1: one-cycle pulse at the end of digit 3's slot.

## Operation
- **Tick counter.** `Tick` counts 0..`TICKS_PER_DIGIT`-1, then wraps to 0. Width is clog2(`TICKS_PER_DIGIT`).
- **Slot end.** A slot ends when `Tick` = `TICKS_PER_DIGIT`-1. At that point `Count` increments mod 4 (3→0 wraps).
- **FSM states.**
  - BLANK: `Tick` < `BLANK_TICKS`.
  - SHOW: otherwise.
  - BLANK→SHOW when `Tick` reaches `BLANK_TICKS`-1.
  - SHOW→BLANK at slot end.
  - The FSM always enters BLANK on a new slot.
- **Segments.**
  - BLANK, or the active-shadow enable bit for `Count` is 0: `Segments` = 7'b1111111.
  - Otherwise: `Segments` = hex decode of the active-shadow nibble[`Count`].
- **Hex decode (g..a), 0..F:** 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- **Double buffer.**
  - `Load` copies `Value`/`DigitEnable` into staging and sets `Pending`.
  - At a frame boundary (slot end with `Count`=3), if `Pending` is set, staging copies into the active shadow and `Pending` clears.
  - The active shadow never changes mid-frame, so there is no tearing.
- **Load coinciding with a frame boundary.** The `Value` present on that cycle commits to the active shadow directly. `Pending` ends cleared.
- **Repeated `Load` within one frame.** The last one wins.
- **Reset.** Takes priority over everything and may be asserted at any time, including mid-slot or mid-frame. Reset state:
  - `Tick`=0, `Count`=0, FSM=BLANK
  - staging and active shadow = 0, enables 0, `Pending`=0
  - `Segments`=7'b1111111, `FrameDone`=0

## Timing
- All outputs are registered.
- `Count`, `Segments`, and FSM state update on the same edge, so they are mutually consistent every cycle. `Segments` always corresponds to the digit `Count` selects.
- The digit change and the start of BLANK occur on the same edge.
- `FrameDone` is high for exactly the one cycle after the edge where `Count` goes 3→0. It is coincident with `Count`=0, `Tick`=0.
- Load-to-display latency runs from the `Load` edge to the next frame boundary: at most 4·`TICKS_PER_DIGIT` cycles, and at least 1 cycle when `Load` lands on the boundary.
- First release from reset:
  - Cycle 0 after `Reset` deasserts has `Tick`=0.
  - The first SHOW cycle is at `Tick`=`BLANK_TICKS`.
  - Nothing lights until the first committed load (enables are 0).
- Full frame period = 4·`TICKS_PER_DIGIT` cycles. Each digit is lit for (`TICKS_PER_DIGIT`-`BLANK_TICKS`) cycles per frame.

## Test plan
Parameters for all scenarios: `TICKS_PER_DIGIT`=8, `BLANK_TICKS`=2.

1. **Reset and free-run.** Reset 3 cycles, then release → `Count` sequence 0,1,2,3,0 with each value held 8 cycles; `Segments`=7'h7F throughout; `FrameDone` pulses every 32 cycles.
2. **Load and display.** `Load` with `Value`=16'h3A0F, `DigitEnable`=4'hF at `Count`=1 → active shadow unchanged until the 3→0 boundary. In the next frame, SHOW cycles show 0001110 (F), 1000000 (0), 0001000 (A), 0110000 (3) for digits 0..3. Each slot's first 2 cycles are 1111111.
3. **Per-digit enable.** `DigitEnable`=4'b0101 with `Value`=16'h8888 → digits 0 and 2 show 0000000 in SHOW; digits 1 and 3 stay 1111111.
4. **Load on boundary, then double load.**
   - `Load` (`Value`=16'h1111) on the exact cycle `Count`=3, `Tick`=7 → digit 0 in the immediately following slot shows 1111001.
   - Two `Load`s in one frame (16'h2222, then 16'h5555) → only 0010010 (5) is displayed next frame.
5. **Mid-operation reset.** Assert `Reset` at `Count`=2, `Tick`=5 with digits lit → next cycle `Count`=0, `Segments`=7'h7F, `FrameDone`=0. After release, the display stays dark until a new `Load` commits.
